// File: rtl/scratch_mem_arbiter_pkg.sv
// Shared definitions for the histogram scratch-memory arbiter:
// requester indices, FSM states and default widths.
package scratch_mem_arbiter_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_HIST = 0;
    localparam int REQ_CDF  = 1;
    localparam int REQ_EQ   = 2;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic logic [1:0] next_ptr(input logic [1:0] k);
        return (k == 2'(NUM_REQ - 1)) ? 2'd0 : k + 2'd1;
    endfunction

endpackage

// File: rtl/scratch_mem_arbiter_rr_priority_pick.sv
// Round-robin winner: first set request scanning upward from rr_ptr,
// wrapping modulo the requester count.
module rr_priority_pick
    import scratch_mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         rr_ptr,
    output logic [NUM_REQ-1:0] win
);

    int idx;

    // Scan from the farthest offset down so the nearest one wins last.
    always_comb begin
        win = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Shares the single-port histogram scratch RAM between three stages with
// round-robin burst grants, a fairness cap and a fixed-latency read return.
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          acc,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam logic [6:0] CAP = 7'(MAX_BURST - 1);

    arb_state_e         state, state_nx;
    logic [NUM_REQ-1:0] gnt_nx, pick;
    logic [1:0]         rr_ptr, rr_ptr_nx, owner;
    logic [6:0]         burst_cnt, burst_nx;
    logic               access, own_req, others, cap_hit;

    logic [RD_LAT-1:0]  tag_v;
    logic [1:0]         tag_o [RD_LAT];

    rr_priority_pick u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (pick)
    );

    always_comb begin
        owner = 2'(REQ_HIST);
        unique case (1'b1)
            gnt[REQ_CDF]: owner = 2'(REQ_CDF);
            gnt[REQ_EQ]:  owner = 2'(REQ_EQ);
            default:      owner = 2'(REQ_HIST);
        endcase
    end

    assign own_req = |(gnt & req);
    assign access  = |(gnt & req & acc);
    assign others  = |(req & ~gnt);
    // Fairness cap only bites when someone else is actually waiting.
    assign cap_hit = access && others && (burst_cnt >= CAP);

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        rr_ptr_nx = rr_ptr;
        burst_nx  = burst_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nx   = pick;
                    state_nx = OWNED;
                end
            end
            OWNED: begin
                if (!own_req || cap_hit) begin
                    state_nx  = IDLE;
                    gnt_nx    = '0;
                    rr_ptr_nx = next_ptr(owner);
                    burst_nx  = '0;
                end else if (access && burst_cnt != 7'h7f) begin
                    burst_nx = burst_cnt + 7'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_nx;
        end
    end

    assign mem_en = access;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (|gnt) begin
            mem_we    = we[owner];
            mem_addr  = addr[owner*ADDR_W +: ADDR_W];
            mem_wdata = wdata[owner*DATA_W +: DATA_W];
        end
    end

    // Read tags travel alongside the RAM latency so data returns to its issuer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_o[i] <= '0;
        end else begin
            tag_v[0] <= mem_en & ~mem_we;
            tag_o[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
        end
    end

    assign rvalid = tag_v[RD_LAT-1] ? (NUM_REQ'(1) << tag_o[RD_LAT-1]) : '0;
    assign rdata  = tag_v[RD_LAT-1] ? mem_rdata : '0;

endmodule
